dtm_v2: RTL and testbench

DTM_V2 -- requirements
Module: dtm_v2

---
 rtl/dtm_v2.sv | 242 ++++++++++++++++++++++++
 tb/tb_dtm_v2.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtm_v2.sv
// JTAG debug transport module: IEEE 1149.1 TAP with IDCODE, DTMCS, DMI and BYPASS
// data registers, bridging DMI scans to a valid/ready request/response interface.
module dtm_v2 #(
    parameter int          ABITS      = 7,
    parameter int          IR_WIDTH   = 5,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
    parameter logic [2:0]  IDLE_HINT  = 3'd5
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op,
    output logic             dmi_hardreset
);

    localparam int                  DMI_W      = ABITS + 34;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS   = IR_WIDTH'(5'h10);
    localparam logic [IR_WIDTH-1:0] IR_DMI     = IR_WIDTH'(5'h11);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
    localparam logic [5:0]          ABITS_F    = 6'(ABITS);

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR,
        TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_e;
    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;
    typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_e;

    tap_e                tap_r, tap_nxt_s;
    dmi_e                dmi_r, dmi_nxt_s;
    dr_sel_e             dr_sel_s;
    logic                capture_dr_s, shift_dr_s, update_dr_s;
    logic                capture_ir_s, shift_ir_s, update_ir_s, tlr_s;
    logic [IR_WIDTH-1:0] ir_r, ir_shift_r;
    logic [DMI_W-1:0]    dr_shift_r, dr_shift_nxt_s, dr_capture_s;
    logic [1:0]          sticky_r, sticky_resp_s, cap_op_s;
    logic [31:0]         resp_data_r, resp_data_now_s, dtmcs_s;
    logic [ABITS-1:0]    dmi_req_addr_r;
    logic [31:0]         dmi_req_data_r;
    logic [1:0]          dmi_req_op_r;
    logic                dmi_req_valid_r, dmi_resp_ready_r, dmi_hardreset_r, tdo_r;
    logic                dmi_req_valid_s, dmi_resp_ready_s;
    logic                dmi_cap_s, dmi_upd_s, dtmcs_upd_s, dmireset_s, hardreset_s;
    logic                dmi_busy_s, resp_fire_s, start_s;

    // TAP state register
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) tap_r <= TAP_TLR;
        else      tap_r <= tap_nxt_s;
    end

    // TAP next-state: IEEE 1149.1 transition table
    always_comb begin
        tap_nxt_s = tap_r;
        case (tap_r)
            TAP_TLR:    tap_nxt_s = TMS ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    tap_nxt_s = TMS ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: tap_nxt_s = TMS ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: tap_nxt_s = TMS ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  tap_nxt_s = TMS ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: tap_nxt_s = TMS ? TAP_UPD_DR : TAP_PA_DR;
            TAP_PA_DR:  tap_nxt_s = TMS ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: tap_nxt_s = TMS ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: tap_nxt_s = TMS ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: tap_nxt_s = TMS ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: tap_nxt_s = TMS ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  tap_nxt_s = TMS ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: tap_nxt_s = TMS ? TAP_UPD_IR : TAP_PA_IR;
            TAP_PA_IR:  tap_nxt_s = TMS ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: tap_nxt_s = TMS ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: tap_nxt_s = TMS ? TAP_SEL_DR : TAP_RTI;
            default:    tap_nxt_s = TAP_TLR;
        endcase
    end

    // TAP state decode strobes
    always_comb begin
        tlr_s        = (tap_r == TAP_TLR);
        capture_dr_s = (tap_r == TAP_CAP_DR);
        shift_dr_s   = (tap_r == TAP_SH_DR);
        update_dr_s  = (tap_r == TAP_UPD_DR);
        capture_ir_s = (tap_r == TAP_CAP_IR);
        shift_ir_s   = (tap_r == TAP_SH_IR);
        update_ir_s  = (tap_r == TAP_UPD_IR);
    end

    // Instruction shift register and latched instruction
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_shift_r <= {IR_WIDTH{1'b0}};
            ir_r       <= IR_IDCODE;
        end else begin
            if (capture_ir_s)    ir_shift_r <= IR_CAPTURE;
            else if (shift_ir_s) ir_shift_r <= {TDI, ir_shift_r[IR_WIDTH-1:1]};
            if (tlr_s)            ir_r <= IR_IDCODE;
            else if (update_ir_s) ir_r <= ir_shift_r;
        end
    end

    // Data register selection from the latched instruction
    always_comb begin
        case (ir_r)
            IR_IDCODE: dr_sel_s = DR_IDCODE;
            IR_DTMCS:  dr_sel_s = DR_DTMCS;
            IR_DMI:    dr_sel_s = DR_DMI;
            default:   dr_sel_s = DR_BYPASS;
        endcase
    end

    // DMI request/response bookkeeping; a response landing this cycle counts as done
    always_comb begin
        resp_fire_s     = (dmi_r == DMI_WAIT) && dmi_resp_valid;
        dmi_busy_s      = (dmi_r == DMI_REQ) || ((dmi_r == DMI_WAIT) && !dmi_resp_valid);
        resp_data_now_s = resp_fire_s ? dmi_resp_data : resp_data_r;
        if (resp_fire_s && (dmi_resp_op == 2'd2) && (sticky_r == 2'd0)) sticky_resp_s = 2'd2;
        else                                                             sticky_resp_s = sticky_r;
        cap_op_s    = dmi_busy_s ? 2'd3 : sticky_resp_s;
        dmi_cap_s   = capture_dr_s && (dr_sel_s == DR_DMI);
        dmi_upd_s   = update_dr_s && (dr_sel_s == DR_DMI);
        dtmcs_upd_s = update_dr_s && (dr_sel_s == DR_DTMCS);
        dmireset_s  = dtmcs_upd_s && dr_shift_r[16];
        hardreset_s = dtmcs_upd_s && dr_shift_r[17];
        start_s     = dmi_upd_s && !dmi_busy_s && (sticky_resp_s == 2'd0) &&
                      ((dr_shift_r[1:0] == 2'd1) || (dr_shift_r[1:0] == 2'd2));
        dtmcs_s     = {14'd0, 2'd0, 1'b0, IDLE_HINT, sticky_resp_s, ABITS_F, 4'd1};
    end

    // Capture value and next shift value for the selected data register
    always_comb begin
        case (dr_sel_s)
            DR_DMI: begin
                dr_capture_s   = {dmi_req_addr_r, resp_data_now_s, cap_op_s};
                dr_shift_nxt_s = {TDI, dr_shift_r[DMI_W-1:1]};
            end
            DR_IDCODE: begin
                dr_capture_s   = DMI_W'({IDCODE_VAL[31:1], 1'b1});
                dr_shift_nxt_s = DMI_W'({TDI, dr_shift_r[31:1]});
            end
            DR_DTMCS: begin
                dr_capture_s   = DMI_W'(dtmcs_s);
                dr_shift_nxt_s = DMI_W'({TDI, dr_shift_r[31:1]});
            end
            default: begin
                dr_capture_s   = {DMI_W{1'b0}};
                dr_shift_nxt_s = DMI_W'(TDI);
            end
        endcase
    end

    // Data shift register
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)              dr_shift_r <= {DMI_W{1'b0}};
        else if (capture_dr_s) dr_shift_r <= dr_capture_s;
        else if (shift_dr_s)   dr_shift_r <= dr_shift_nxt_s;
    end

    // TDO driven on the falling edge so the host samples a settled bit
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST)            tdo_r <= 1'b0;
        else if (shift_dr_s) tdo_r <= dr_shift_r[0];
        else if (shift_ir_s) tdo_r <= ir_shift_r[0];
        else                 tdo_r <= 1'b0;
    end

    // DMI FSM state register
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) dmi_r <= DMI_IDLE;
        else      dmi_r <= dmi_nxt_s;
    end

    // DMI FSM next state; hard reset aborts any outstanding request
    always_comb begin
        dmi_nxt_s = dmi_r;
        if (hardreset_s) begin
            dmi_nxt_s = DMI_IDLE;
        end else begin
            case (dmi_r)
                DMI_IDLE: dmi_nxt_s = start_s ? DMI_REQ : DMI_IDLE;
                DMI_REQ:  dmi_nxt_s = dmi_req_ready ? DMI_WAIT : DMI_REQ;
                DMI_WAIT: begin
                    if (start_s)             dmi_nxt_s = DMI_REQ;
                    else if (dmi_resp_valid) dmi_nxt_s = DMI_IDLE;
                    else                     dmi_nxt_s = DMI_WAIT;
                end
                default:  dmi_nxt_s = DMI_IDLE;
            endcase
        end
    end

    // DMI FSM output decode, taken from the next state so outputs can be registered
    always_comb begin
        dmi_req_valid_s  = (dmi_nxt_s == DMI_REQ);
        dmi_resp_ready_s = (dmi_nxt_s == DMI_WAIT);
    end

    // Registered DMI handshake outputs, request fields, response data and sticky status
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            dmi_req_valid_r  <= 1'b0;
            dmi_resp_ready_r <= 1'b0;
            dmi_hardreset_r  <= 1'b0;
            dmi_req_addr_r   <= {ABITS{1'b0}};
            dmi_req_data_r   <= 32'd0;
            dmi_req_op_r     <= 2'd0;
            resp_data_r      <= 32'd0;
            sticky_r         <= 2'd0;
        end else begin
            dmi_req_valid_r  <= dmi_req_valid_s;
            dmi_resp_ready_r <= dmi_resp_ready_s;
            dmi_hardreset_r  <= hardreset_s;
            if (start_s) begin
                dmi_req_addr_r <= dr_shift_r[DMI_W-1:34];
                dmi_req_data_r <= dr_shift_r[33:2];
                dmi_req_op_r   <= dr_shift_r[1:0];
            end
            if (resp_fire_s) resp_data_r <= dmi_resp_data;
            if (hardreset_s || dmireset_s)                sticky_r <= 2'd0;
            else if ((dmi_cap_s || dmi_upd_s) && dmi_busy_s) sticky_r <= 2'd3;
            else                                          sticky_r <= sticky_resp_s;
        end
    end

    assign TDO            = tdo_r;
    assign dmi_req_valid  = dmi_req_valid_r;
    assign dmi_resp_ready = dmi_resp_ready_r;
    assign dmi_hardreset  = dmi_hardreset_r;
    assign dmi_req_addr   = dmi_req_addr_r;
    assign dmi_req_data   = dmi_req_data_r;
    assign dmi_req_op     = dmi_req_op_r;

endmodule

// File: tb/tb_dtm_v2.sv
// Directed bench for dtm_v2: table of register scans plus hand-written DMI sequences
// against a simple DMI responder.
module tb_dtm_v2;

    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        TMS = 1'b1;
    logic        TDI = 1'b0;
    logic        TDO;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_op;
    logic        dmi_hardreset;

    int tests = 0;
    int fails = 0;

    int          ready_delay = 0;
    int          rdy_cnt = 0;
    int          hs_count = 0;
    int          resp_count = 0;
    int          hr_count = 0;
    bit          resp_en = 1'b0;
    bit          manual_resp = 1'b0;
    logic        auto_valid = 1'b0;
    logic        man_valid = 1'b0;
    logic [31:0] auto_data = 32'd0;
    logic [31:0] man_data = 32'd0;
    logic [1:0]  auto_op = 2'd0;
    logic [31:0] resp_data_cfg = 32'd0;
    logic [1:0]  resp_op_cfg = 2'd0;
    logic [6:0]  log_addr = 7'd0;
    logic [31:0] log_data = 32'd0;
    logic [1:0]  log_op = 2'd0;

    assign dmi_resp_valid = manual_resp ? man_valid : auto_valid;
    assign dmi_resp_data  = manual_resp ? man_data : auto_data;
    assign dmi_resp_op    = manual_resp ? 2'd0 : auto_op;

    dtm_v2 dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op),
        .dmi_hardreset(dmi_hardreset)
    );

    always #5 TCK = ~TCK;

    // DMI responder: raises ready after ready_delay cycles, answers one cycle after ready
    initial begin
        forever begin
            @(negedge TCK);
            if (dmi_hardreset) hr_count++;
            if (!manual_resp) begin
                if (auto_valid) begin
                    auto_valid = 1'b0;
                end else if (dmi_resp_ready && resp_en) begin
                    auto_valid = 1'b1;
                    auto_data  = resp_data_cfg;
                    auto_op    = resp_op_cfg;
                    resp_count++;
                end
            end
            if (dmi_req_ready) begin
                dmi_req_ready = 1'b0;
            end else if (dmi_req_valid) begin
                if (rdy_cnt >= ready_delay) begin
                    dmi_req_ready = 1'b1;
                    log_addr = dmi_req_addr;
                    log_data = dmi_req_data;
                    log_op   = dmi_req_op;
                    hs_count++;
                    rdy_cnt = 0;
                end else begin
                    rdy_cnt++;
                end
            end else begin
                rdy_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        @(negedge TCK); #1;
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic ir_scan(input logic [4:0] v, output logic [4:0] cap);
        cap = 5'd0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge TCK); #1;
            TMS = (i == 4);
            TDI = v[i];
            cap[i] = TDO;
            @(posedge TCK);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Full DR scan from Run-Test/Idle; rcap puts a DMI response on the capture edge
    task automatic dr_scan(input int n, input logic [63:0] din, input bit rcap,
                           input logic [31:0] rdata, output logic [63:0] dout);
        dout = 64'd0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        @(negedge TCK); #1;
        TMS = 1'b0;
        if (rcap) begin
            man_valid = 1'b1;
            man_data  = rdata;
        end
        @(posedge TCK);
        for (int i = 0; i < n; i++) begin
            @(negedge TCK); #1;
            if (rcap) man_valid = 1'b0;
            TMS = (i == n - 1);
            TDI = din[i];
            dout[i] = TDO;
            @(posedge TCK);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic dscan(input int n, input logic [63:0] din, output logic [63:0] dout);
        dr_scan(n, din, 1'b0, 32'd0, dout);
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int i = 0; i < 60; i++) begin
            if (hs_count >= target) break;
            tick(1'b0, 1'b0);
        end
        check(name, 64'(hs_count >= target), 64'd1);
    endtask

    task automatic wait_resp(input int target, input string name);
        for (int i = 0; i < 60; i++) begin
            if (resp_count >= target) break;
            tick(1'b0, 1'b0);
        end
        check(name, 64'(resp_count >= target), 64'd1);
        idle(2);
    endtask

    typedef struct {
        logic [4:0]  ir;
        int          n;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[9];
    logic [4:0]  irc;
    logic [63:0] dout;

    initial begin
        vecs[0] = '{5'h01, 32, 64'h0, 64'h0000_0001};
        vecs[1] = '{5'h01, 34, 64'h1, 64'h1_0000_0001};
        vecs[2] = '{5'h10, 32, 64'h0, 64'h0000_5071};
        vecs[3] = '{5'h1F, 2,  64'h3, 64'h2};
        vecs[4] = '{5'h00, 3,  64'h5, 64'h2};
        vecs[5] = '{5'h11, 41, 64'h0, 64'h0};
        vecs[6] = '{5'h11, 41, 64'h0, 64'h0};
        vecs[7] = '{5'h05, 1,  64'h1, 64'h0};
        vecs[8] = '{5'h10, 32, 64'h0, 64'h0000_5071};

        #1 TRST = 1'b1;
        #2;
        check("rst_tdo", 64'(TDO), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready), 64'd0);
        check("rst_hardreset", 64'(dmi_hardreset), 64'd0);
        repeat (3) @(negedge TCK);
        #1 TRST = 1'b0;
        tick(1'b0, 1'b0);

        for (int k = 0; k < 9; k++) begin
            ir_scan(vecs[k].ir, irc);
            check("ir_capture", 64'(irc), 64'h01);
            dscan(vecs[k].n, vecs[k].din, dout);
            check($sformatf("vec%0d", k), dout, vecs[k].exp);
        end
        check("no_req_from_nops", 64'(hs_count), 64'd0);

        // DMI write with delayed ready, ok response
        ir_scan(5'h11, irc);
        ready_delay = 3; resp_en = 1'b1; resp_op_cfg = 2'd0; resp_data_cfg = 32'hCAFE_0001;
        dscan(41, 64'({7'h10, 32'hDEAD_BEEF, 2'd2}), dout);
        wait_hs(1, "wr_handshake");
        wait_resp(1, "wr_response");
        check("wr_addr", 64'(log_addr), 64'h10);
        check("wr_data", 64'(log_data), 64'hDEAD_BEEF);
        check("wr_op", 64'(log_op), 64'd2);
        dscan(41, 64'd0, dout);
        check("wr_capture", dout, 64'({7'h10, 32'hCAFE_0001, 2'd0}));

        // Read left pending: busy capture, then everything blocked until dmireset
        resp_en = 1'b0; ready_delay = 0; resp_data_cfg = 32'h1111_2222;
        dscan(41, 64'({7'h05, 32'h0, 2'd1}), dout);
        wait_hs(2, "rd_handshake");
        idle(1);
        dscan(41, 64'd0, dout);
        check("busy_op", 64'(dout[1:0]), 64'd3);
        resp_en = 1'b1;
        wait_resp(2, "rd_response");
        dscan(41, 64'({7'h06, 32'h0, 2'd1}), dout);
        check("sticky_op", 64'(dout[1:0]), 64'd3);
        idle(6);
        check("blocked_no_req", 64'(hs_count), 64'd2);
        check("blocked_valid", 64'(dmi_req_valid), 64'd0);
        ir_scan(5'h10, irc);
        dscan(32, 64'd0, dout);
        check("dtmcs_busy", dout, 64'h5C71);
        dscan(32, 64'h1_0000, dout);
        dscan(32, 64'd0, dout);
        check("dtmcs_cleared", dout, 64'h5071);
        ir_scan(5'h11, irc);
        dscan(41, 64'd0, dout);
        check("rd_capture", dout, 64'({7'h05, 32'h1111_2222, 2'd0}));

        // Failed response sets sticky 2, cleared by dmireset
        resp_op_cfg = 2'd2; resp_data_cfg = 32'hBAD0_0000;
        dscan(41, 64'({7'h07, 32'h0, 2'd1}), dout);
        wait_hs(3, "err_handshake");
        wait_resp(3, "err_response");
        dscan(41, 64'd0, dout);
        check("err_capture", dout, 64'({7'h07, 32'hBAD0_0000, 2'd2}));
        resp_op_cfg = 2'd0;
        ir_scan(5'h10, irc);
        dscan(32, 64'h1_0000, dout);
        check("dtmcs_err", dout, 64'h5871);
        dscan(32, 64'd0, dout);
        check("dtmcs_err_cleared", dout, 64'h5071);
        ir_scan(5'h11, irc);

        // Response coincident with Capture-DR completes first
        resp_en = 1'b0; manual_resp = 1'b1;
        dscan(41, 64'({7'h09, 32'h0, 2'd1}), dout);
        wait_hs(4, "coin_handshake");
        idle(1);
        check("coin_ready", 64'(dmi_resp_ready), 64'd1);
        dr_scan(41, 64'd0, 1'b1, 32'h5555_AAAA, dout);
        check("coin_capture", dout, 64'({7'h09, 32'h5555_AAAA, 2'd0}));
        check("coin_done", 64'(dmi_resp_ready), 64'd0);
        manual_resp = 1'b0;

        // Hard reset while a request waits for ready
        ready_delay = 1000;
        dscan(41, 64'({7'h0A, 32'h0, 2'd1}), dout);
        idle(2);
        check("hr_pending_valid", 64'(dmi_req_valid), 64'd1);
        check("hr_pending_addr", 64'(dmi_req_addr), 64'h0A);
        ir_scan(5'h10, irc);
        hr_count = 0;
        dscan(32, 64'h2_0000, dout);
        #1;
        check("hr_pulse_high", 64'(dmi_hardreset), 64'd1);
        check("hr_valid_dropped", 64'(dmi_req_valid), 64'd0);
        tick(1'b0, 1'b0);
        #1;
        check("hr_pulse_low", 64'(dmi_hardreset), 64'd0);
        idle(3);
        check("hr_pulse_width", 64'(hr_count), 64'd1);
        check("hr_no_handshake", 64'(hs_count), 64'd4);
        check("hr_resp_ready", 64'(dmi_resp_ready), 64'd0);
        ready_delay = 0;
        ir_scan(5'h1F, irc);
        dscan(1, 64'h1, dout);
        check("bypass_1bit", dout, 64'h0);
        dscan(3, 64'h5, dout);
        check("bypass_3bit", dout, 64'h2);
        ir_scan(5'h11, irc);
        dscan(41, 64'd0, dout);
        check("hr_capture_op", 64'(dout[1:0]), 64'd0);

        // TRST in the middle of a transaction; a late response is ignored
        resp_en = 1'b0;
        dscan(41, 64'({7'h0B, 32'h0, 2'd1}), dout);
        wait_hs(5, "trst_handshake");
        idle(1);
        check("trst_pre_ready", 64'(dmi_resp_ready), 64'd1);
        @(negedge TCK); #2;
        TRST = 1'b1;
        #1;
        check("trst_resp_ready", 64'(dmi_resp_ready), 64'd0);
        check("trst_req_valid", 64'(dmi_req_valid), 64'd0);
        manual_resp = 1'b1; man_valid = 1'b1; man_data = 32'hFFFF_0000;
        #20;
        @(negedge TCK); #1;
        TRST = 1'b0;
        idle(3);
        check("late_resp_ignored", 64'(dmi_resp_ready), 64'd0);
        man_valid = 1'b0; manual_resp = 1'b0;
        dscan(32, 64'd0, dout);
        check("trst_idcode", dout, 64'h1);
        ir_scan(5'h11, irc);
        dscan(41, 64'd0, dout);
        check("trst_dmi_capture", dout, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
